// File: rtl/smg_scan_module_if.sv
// Bus between the value source and the 7-segment scan controller.
// The master side supplies the BCD value and controls; the slave side
// (the scan controller) returns the encoder nibble, digit enables and slot tick.
interface smg_scan_module_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] BcdIn;
  logic                Load;
  logic                LzEn;
  logic [3:0]          NumberData;
  logic [DIGITS-1:0]   DigitSel;
  logic                SlotTick;

  modport master (
    output BcdIn, Load, LzEn,
    input  NumberData, DigitSel, SlotTick
  );

  modport slave (
    input  BcdIn, Load, LzEn,
    output NumberData, DigitSel, SlotTick
  );
endinterface

// File: rtl/smg_scan_module.sv
// Multiplexed scan controller for an N-digit 7-segment display.
// A loaded value waits in a shadow register and is promoted to the displayed
// value only at a frame boundary, so one frame never mixes two values.
// Each slot starts with BLANK_CYC cycles of all digits off, which hides the
// segment encoder latency and prevents ghosting from the previous digit.
module smg_scan_module #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  smg_scan_module_if.slave bus
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = $clog2(DIGITS);
  localparam int VAL_W  = 4 * DIGITS;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t              state_q;
  logic                run_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [VAL_W-1:0]    shadow_q, shadow_d;
  logic [VAL_W-1:0]    active_q, active_d;
  logic                pending_q, pending_d;
  logic [3:0]          NumberData_q;
  logic [DIGITS-1:0]   DigitSel_q;
  logic                SlotTick_q;

  logic                slot_end, frame_end, drive_edge, blanked;
  logic [3:0]          cur_nib;
  logic [VAL_W-1:0]    upper;

  assign bus.NumberData = NumberData_q;
  assign bus.DigitSel   = DigitSel_q;
  assign bus.SlotTick   = SlotTick_q;

  // Next-state for timing, value registers and the digit-blank decision.
  // run_q holds the counter at 0 for the first edge out of reset so that the
  // first visible cycle after release is cnt==0 with its slot tick.
  always_comb begin
    slot_end   = run_q && (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end  = slot_end && (slot_q == SLOT_W'(DIGITS - 1));
    drive_edge = run_q && (state_q == BLANK) && (cnt_q == CNT_W'(BLANK_CYC - 1));

    cnt_d = (!run_q || slot_end) ? '0 : cnt_q + CNT_W'(1);

    slot_d = slot_q;
    if (slot_end)
      slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);

    shadow_d  = bus.Load ? bus.BcdIn : shadow_q;
    pending_d = frame_end ? 1'b0 : (bus.Load | pending_q);

    // A Load in the swap cycle itself goes straight to the display.
    active_d = active_q;
    if (frame_end) begin
      if (bus.Load)
        active_d = bus.BcdIn;
      else if (pending_q)
        active_d = shadow_q;
    end

    cur_nib = active_q[{slot_q, 2'b00} +: 4];
    upper   = active_q >> {slot_q, 2'b00};
    blanked = (cur_nib > 4'd9) ||
              (bus.LzEn && (slot_q != '0) && (upper == '0));
  end

  // Scan FSM with all counters, value registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      slot_q       <= '0;
      state_q      <= BLANK;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      NumberData_q <= 4'd0;
      DigitSel_q   <= '1;
      SlotTick_q   <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      SlotTick_q <= (cnt_d == '0);
      if (slot_end) begin
        state_q      <= BLANK;
        DigitSel_q   <= '1;
        NumberData_q <= active_d[{slot_d, 2'b00} +: 4];
      end else if (drive_edge) begin
        state_q    <= DRIVE;
        DigitSel_q <= blanked ? '1 : ~(DIGITS'(1) << slot_q);
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_module.sv
// Directed bench for smg_scan_module with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_smg_scan_module;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  smg_scan_module_if #(.DIGITS(4)) bus ();

  smg_scan_module #(
    .DIGITS   (4),
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .CLK (clk),
    .RSTn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Positioned at the falling edge of cnt==0; checks ncyc cycles of one slot.
  // An optional Load of load_val is applied in cycle cnt==load_at.
  task automatic run_slot(input string nm, input logic [3:0] nd, input logic [3:0] sel,
                          input int ncyc, input int load_at, input logic [15:0] load_val);
    for (int i = 0; i < ncyc; i++) begin
      chk($sformatf("%s_c%0d_sel", nm, i), bus.DigitSel, (i < 2) ? 4'hF : sel);
      chk($sformatf("%s_c%0d_nd", nm, i), bus.NumberData, nd);
      chk($sformatf("%s_c%0d_tick", nm, i), bus.SlotTick, (i == 0) ? 1'b1 : 1'b0);
      if (i == load_at) begin
        bus.Load  = 1'b1;
        bus.BcdIn = load_val;
      end
      @(negedge clk);
      bus.Load = 1'b0;
    end
  endtask

  // nds/sels hold the expected nibble and DigitSel for slot i in nibble i.
  task automatic run_frame(input string nm, input logic [15:0] nds, input logic [15:0] sels,
                           input int load_slot, input int load_at, input logic [15:0] load_val);
    for (int s = 0; s < 4; s++)
      run_slot($sformatf("%s_s%0d", nm, s), nds[4*s +: 4], sels[4*s +: 4], 8,
               (s == load_slot) ? load_at : -1, load_val);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    bus.BcdIn = 16'h0000;
    bus.Load  = 1'b0;
    bus.LzEn  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sel", bus.DigitSel, 4'hF);
    chk("rst_nd", bus.NumberData, 4'h0);
    chk("rst_tick", bus.SlotTick, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // Frame 1 displays 0; Load 1234 mid-frame appears in frame 2.
    run_frame("f1", 16'h0000, 16'h7BDE, 0, 3, 16'h1234);
    // Frame 2: Load 5678 during slot 1 must not tear this frame.
    run_frame("f2", 16'h1234, 16'h7BDE, 1, 4, 16'h5678);
    // Frame 3: Load 12A4 in the swap cycle itself.
    run_frame("f3", 16'h5678, 16'h7BDE, 3, 7, 16'h12A4);
    // Frame 4: non-BCD nibble in slot 1 is blanked; enable zero suppression.
    bus.LzEn = 1'b1;
    run_frame("f4", 16'h12A4, 16'h7BFE, 0, 1, 16'h0042);
    // Frame 5: leading zeros blanked; two Loads in one frame, last wins.
    run_frame("f5a", 16'h0042, 16'hFFDE, -1, -1, 16'h0000);
    run_slot("f5b_s0", 4'h2, 4'hE, 8, -1, 16'h0000);
    run_slot("f5b_s1", 4'h4, 4'hD, 8, 6, 16'h9999);
    run_slot("f5b_s2", 4'h0, 4'hF, 8, 3, 16'h0000);
    run_slot("f5b_s3", 4'h0, 4'hF, 8, -1, 16'h0000);
    // All-zero value: only slot 0 lit.
    run_frame("f6", 16'h0000, 16'hFFFE, 3, 2, 16'h1234);
    bus.LzEn = 1'b0;

    // Reset in the middle of slot 2 (asserted during cnt==5).
    run_slot("f7_s0", 4'h4, 4'hE, 8, -1, 16'h0000);
    run_slot("f7_s1", 4'h3, 4'hD, 8, -1, 16'h0000);
    run_slot("f7_s2", 4'h2, 4'hB, 5, -1, 16'h0000);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_sel", bus.DigitSel, 4'hF);
    chk("mid_rst_nd", bus.NumberData, 4'h0);
    chk("mid_rst_tick", bus.SlotTick, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    run_frame("f8", 16'h0000, 16'h7BDE, -1, -1, 16'h0000);
    run_slot("f9_s0", 4'h0, 4'hE, 8, -1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
